bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Parametrised multi-digit BCD/hex 7-segment display driver for the guess-the-number AXI peripheral. It latches a packed multi-digit value and time-multiplexes it onto a shared segment bus, with a per-digit anode strobe and a one-cycle ghosting guard. It also provides decimal points, leading-zero suppression, global blanking and frame-synchronised (tear-free) value updates. It sits between the AXI register file and the board's segment/anode pins, and replaces the single-digit combinational decoder.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- CLK_DIV, 100000, clock cycles per digit slot (>= 4)
- HEX_EN, 1, 1: codes 0xA-0xF shown as A,b,C,d,E,F; 0: shown as a dash (segment g only)
- SEG_ACTIVE_LOW, 1, polarity of seg_out and dp_out
- AN_ACTIVE_LOW, 1, polarity of an_out

Ports:
- s00_axi_aclk  in  1  single clock, rising edge
- s00_axi_aresetn  in  1  reset, asynchronous assert, active-low
- value_in  in  4*NUM_DIGITS  packed digit codes; digit 0 = bits [3:0] = least significant
- dp_in  in  NUM_DIGITS  decimal-point enable per digit
- load  in  1  one-cycle strobe: capture value_in/dp_in
- lz_en  in  1  leading-zero suppression enable
- blank_in  in  1  force all anodes inactive
- seg_out  out  7  segments {a,b,c,d,e,f,g}; a = bit 6, g = bit 0
- dp_out  out  1  decimal-point segment
- an_out  out  NUM_DIGITS  one-hot anode drive
- digit_idx  out  clog2(NUM_DIGITS), min 1  index of the digit currently addressed
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0
- busy  out  1  high while a captured load waits for the frame boundary

## Operation
- Decode, active-high form (inverted when SEG_ACTIVE_LOW=1): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
- Active-low results: 0→0x01, 1→0x4F, 8→0x00.
- HEX_EN=1, active-high: A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- HEX_EN=0: codes A-F decode to 01 (active-high).
- Loading path: value_in/dp_in go to pending registers; the shadow registers feed the display.
- load with the scan mid-frame: capture into pending, set busy.
- Frame boundary (frame_done cycle): if busy, copy pending to shadow and clear busy.
- load while already busy: overwrite pending; only the latest value is used.
- load in the same cycle as frame_done: new value goes straight to shadow; busy stays 0.
- Leading-zero suppression (lz_en=1): scan from digit NUM_DIGITS-1 downward. Each digit with code 0 is blanked (segments and dp off) until the first non-zero digit. Digit 0 is never suppressed.
- A suppressed digit with dp set still shows its dp.
- blank_in=1: an_out all inactive. The scan counter keeps running; frame_done continues to pulse.
- Scan state machine:
  - SHOW: drives the current digit.
  - GUARD: anodes inactive for exactly 1 cycle.
  - SHOW → GUARD on slot tick; GUARD → SHOW next cycle.

## Timing
- Reset values: prescaler 0, digit_idx 0, shadow and pending 0, busy 0, frame_done 0, state GUARD.
- Reset values: an_out all inactive, seg_out and dp_out all segments off (0x7F / 1 when active-low).
- First SHOW of digit 0 begins the cycle after reset deassertion.
- Prescaler counts 0..CLK_DIV-1. Tick occurs at the cycle where the count is CLK_DIV-1; the count then wraps to 0.
- Tick at cycle T:
  - T+1: GUARD, anodes inactive, digit_idx incremented (mod NUM_DIGITS).
  - T+2: seg_out/dp_out/an_out for the new digit.
- frame_done is high at T+1 when digit_idx wraps to 0. Shadow updates on that edge, so digit 0 shows the new value at T+2.
- Each digit slot is CLK_DIV cycles: 1 guard + CLK_DIV-1 shown. Frame = NUM_DIGITS*CLK_DIV cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- blank_in takes effect on an_out 1 cycle after it is sampled.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous); the pending load is discarded.
- NUM_DIGITS=1: digit_idx is constant 0; frame_done pulses every tick; the guard cycle is still inserted.

## Test plan
- Reset, NUM_DIGITS=4, CLK_DIV=4, load 0x1234 → an_out cycles digit 0..3 every 4 cycles. seg_out = 0x4C, 0x06, 0x12, 0x4F, with 1 guard cycle (an_out=0xF) before each.
- Load 0x0070 with lz_en=1 → digits 3 and 2 blank (an never active during their slots, seg 0x7F), digit 1 shows 0x0F, digit 0 shows 0x01. With lz_en=0, digits 3 and 2 show 0x01.
- Load 0x5555 mid-frame at digit 1 → busy=1 until frame_done, digits 1-3 keep the old value, new value appears from next digit 0. Second load 0x6666 before the boundary → only 0x6666 shown.
- HEX_EN=0, load 0xABCD → every digit seg_out=0x7E (dash, active-low). HEX_EN=1 → 0x08, 0x60, 0x31, 0x42.
- blank_in=1 for 20 cycles → an_out=0xF throughout, frame_done still pulses every 16 cycles. dp_in=4'b0100 → dp_out=0 only in the digit 2 slot.
- Assert s00_axi_aresetn low mid-slot with busy=1 → outputs immediately at reset values, busy=0. After release, the old pending value is never displayed.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Time-multiplexed multi-digit 7-segment driver with frame-synchronised value
// updates, leading-zero suppression, blanking and a one-cycle anode guard.
module bcd_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 100000,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      lz_en,
  input  logic                      blank_in,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic [IW-1:0]             digit_idx,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_ON = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {GUARD, SHOW} scan_state_t;

  // Kept as a named register so checkers can bind to scan_state directly.
  scan_state_t scan_state;

  logic [CW-1:0]             prescale;
  logic [4*NUM_DIGITS-1:0]   shadow_val, pending_val;
  logic [NUM_DIGITS-1:0]     shadow_dp, pending_dp;
  logic [NUM_DIGITS-1:0]     lead_zero, an_sel;
  logic                      above_zero;
  logic                      tick, wrap, suppress, cur_dp;
  logic [3:0]                cur_code;
  logic [IW-1:0]             next_idx;
  logic [6:0]                show_seg;
  logic                      show_dp;
  logic [NUM_DIGITS-1:0]     show_an;

  function automatic logic [6:0] decode_hi(input logic [3:0] code);
    case (code)
      4'h0: decode_hi = 7'h7E;
      4'h1: decode_hi = 7'h30;
      4'h2: decode_hi = 7'h6D;
      4'h3: decode_hi = 7'h79;
      4'h4: decode_hi = 7'h33;
      4'h5: decode_hi = 7'h5B;
      4'h6: decode_hi = 7'h5F;
      4'h7: decode_hi = 7'h70;
      4'h8: decode_hi = 7'h7F;
      4'h9: decode_hi = 7'h7B;
      4'hA: decode_hi = (HEX_EN != 0) ? 7'h77 : 7'h01;
      4'hB: decode_hi = (HEX_EN != 0) ? 7'h1F : 7'h01;
      4'hC: decode_hi = (HEX_EN != 0) ? 7'h4E : 7'h01;
      4'hD: decode_hi = (HEX_EN != 0) ? 7'h3D : 7'h01;
      4'hE: decode_hi = (HEX_EN != 0) ? 7'h4F : 7'h01;
      default: decode_hi = (HEX_EN != 0) ? 7'h47 : 7'h01;
    endcase
  endfunction

  assign tick     = (prescale == CW'(CLK_DIV - 1));
  assign wrap     = (digit_idx == IW'(NUM_DIGITS - 1));
  assign next_idx = wrap ? '0 : digit_idx + 1'b1;
  assign cur_code = shadow_val[4*int'(digit_idx) +: 4];
  assign cur_dp   = shadow_dp[digit_idx];

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    lead_zero  = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      above_zero   = above_zero && (shadow_val[4*i +: 4] == 4'd0);
      lead_zero[i] = above_zero;
    end
  end

  always_comb begin
    an_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_sel[i] = (int'(digit_idx) == i);
    end
  end

  assign suppress = lz_en && lead_zero[digit_idx];
  assign show_seg = suppress ? SEG_OFF :
                    ((SEG_ACTIVE_LOW != 0) ? ~decode_hi(cur_code) : decode_hi(cur_code));
  assign show_dp  = cur_dp ? DP_ON : ~DP_ON;
  // A suppressed digit keeps its anode only when it still has a dp to show.
  assign show_an  = (blank_in || (suppress && !cur_dp)) ? AN_IDLE :
                    ((AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel);

  // load is a valid-only strobe (no ready): it is always accepted the cycle it
  // is high; busy merely reports a capture still waiting for the frame boundary.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      scan_state  <= GUARD;
      prescale    <= '0;
      digit_idx   <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      pending_val <= '0;
      pending_dp  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      seg_out     <= SEG_OFF;
      dp_out      <= ~DP_ON;
      an_out      <= AN_IDLE;
    end else begin
      frame_done <= 1'b0;
      prescale   <= tick ? '0 : prescale + 1'b1;

      if (load) begin
        pending_val <= value_in;
        pending_dp  <= dp_in;
      end

      // The wrap edge is the frame boundary: a load on that very edge bypasses pending.
      if (tick && wrap) begin
        if (load) begin
          shadow_val <= value_in;
          shadow_dp  <= dp_in;
        end else if (busy) begin
          shadow_val <= pending_val;
          shadow_dp  <= pending_dp;
        end
        busy <= 1'b0;
      end else if (load) begin
        busy <= 1'b1;
      end

      case (scan_state)
        SHOW: begin
          if (tick) begin
            scan_state <= GUARD;
            digit_idx  <= next_idx;
            frame_done <= wrap;
            seg_out    <= SEG_OFF;
            dp_out     <= ~DP_ON;
            an_out     <= AN_IDLE;
          end else begin
            seg_out <= show_seg;
            dp_out  <= show_dp;
            an_out  <= show_an;
          end
        end
        default: begin
          scan_state <= SHOW;
          seg_out    <= show_seg;
          dp_out     <= show_dp;
          an_out     <= show_an;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised bench for bcd_scan_display: an arithmetic display model predicts
// every cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_bcd_scan_display;

  localparam int ND    = 4;
  localparam int DIV   = 4;
  localparam int FRAME = ND * DIV;
  localparam int W     = 23;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*ND-1:0] value_in = '0;
  logic [ND-1:0]   dp_in = '0;
  logic            load = 1'b0;
  logic            lz_en = 1'b0;
  logic            blank_in = 1'b0;

  logic [6:0]    seg_hex, seg_nh;
  logic          dp_hex, dp_nh;
  logic [ND-1:0] an_hex, an_nh;
  logic [1:0]    idx_hex, idx_nh;
  logic          fd_hex, fd_nh, busy_hex, busy_nh;

  bcd_scan_display #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .HEX_EN(1),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .value_in(value_in), .dp_in(dp_in),
    .load(load), .lz_en(lz_en), .blank_in(blank_in), .seg_out(seg_hex), .dp_out(dp_hex),
    .an_out(an_hex), .digit_idx(idx_hex), .frame_done(fd_hex), .busy(busy_hex));

  bcd_scan_display #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .HEX_EN(0),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_nohex (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .value_in(value_in), .dp_in(dp_in),
    .load(load), .lz_en(lz_en), .blank_in(blank_in), .seg_out(seg_nh), .dp_out(dp_nh),
    .an_out(an_nh), .digit_idx(idx_nh), .frame_done(fd_nh), .busy(busy_nh));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Expected item: {seg_hex, seg_nohex, dp, an, idx, frame_done, busy}
  logic [W-1:0] exp_q[$];
  localparam logic [W-1:0] RESET_EXP = {7'h7F, 7'h7F, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0};

  int            mk;
  logic [4*ND-1:0] m_shadow, m_pend;
  logic [ND-1:0]   m_sdp, m_pdp;
  logic            m_busy;
  int tests = 0;
  int fails = 0;

  function automatic logic [6:0] seg_hi(input logic [3:0] code, input bit hex);
    logic [6:0] tbl [16];
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    if (!hex && code > 4'd9) return 7'h01;
    return tbl[code];
  endfunction

  function automatic logic [W-1:0] predict(input int k, input logic [4*ND-1:0] val,
                                           input logic [ND-1:0] dps, input bit lz,
                                           input bit blank, input bit bsy);
    int   d, top;
    bit   guard, sup, dpb;
    logic [3:0] code;
    logic [6:0] sh, sn;
    logic [3:0] an;
    d     = (k / DIV) % ND;
    guard = (k % DIV) == 0;
    if (guard) return {7'h7F, 7'h7F, 1'b1, 4'hF, 2'(d), 1'(d == 0), 1'(bsy)};
    top = -1;
    for (int i = 0; i < ND; i++) if (val[4*i +: 4] != 4'd0) top = i;
    code = val[4*d +: 4];
    dpb  = dps[d];
    sup  = lz && (d > 0) && (d > top);
    sh   = sup ? 7'h7F : ~seg_hi(code, 1'b1);
    sn   = sup ? 7'h7F : ~seg_hi(code, 1'b0);
    an   = (blank || (sup && !dpb)) ? 4'hF : ~(4'b0001 << d);
    return {sh, sn, ~dpb, an, 2'(d), 1'b0, 1'(bsy)};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mk = 0; m_shadow = '0; m_pend = '0; m_sdp = '0; m_pdp = '0; m_busy = 1'b0;
        exp_q.push_back(RESET_EXP);
      end else begin
        mk++;
        if (load) begin
          if (mk % FRAME == 0) begin
            m_shadow = value_in; m_sdp = dp_in; m_busy = 1'b0;
          end else begin
            m_pend = value_in; m_pdp = dp_in; m_busy = 1'b1;
          end
        end else if ((mk % FRAME == 0) && m_busy) begin
          m_shadow = m_pend; m_sdp = m_pdp; m_busy = 1'b0;
        end
        exp_q.push_back(predict(mk, m_shadow, m_sdp, lz_en, blank_in, m_busy));
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s k=%0d: got seg/dp/an/idx/fd/busy=%h expected %h", name, mk, got, exp);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan_hex",   {seg_hex, dp_hex, an_hex, idx_hex, fd_hex, busy_hex}, {e[22:16], e[8:0]});
        check("scan_nohex", {seg_nh,  dp_nh,  an_nh,  idx_nh,  fd_nh,  busy_nh},  {e[15:9],  e[8:0]});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance until the next posedge will be frame phase p.
  task automatic wait_phase(input int p);
    int guard_cnt = 0;
    while (((mk + 1) % FRAME) != p && guard_cnt < 4 * FRAME) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (guard_cnt >= 4 * FRAME) begin
      tests++; fails++;
      $display("FAIL wait_phase: phase %0d not reached, k=%0d", p, mk);
    end
  endtask

  task automatic async_reset_check();
    #3 rst_n = 1'b0;
    #1 check("async_reset", {seg_hex, dp_hex, an_hex, idx_hex, fd_hex, busy_hex}, RESET_EXP[15:0]);
    check("async_reset_nohex", {seg_nh, dp_nh, an_nh, idx_nh, fd_nh, busy_nh}, RESET_EXP[15:0]);
    run(3);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    run(3);
    rst_n = 1'b1;

    drive_load(16'h1234, 4'b0000);
    run(40);

    lz_en = 1'b1;
    drive_load(16'h0070, 4'b0000);
    run(40);
    lz_en = 1'b0;
    run(32);

    wait_phase(6);
    drive_load(16'h5555, 4'b0000);
    run(3);
    drive_load(16'h6666, 4'b0000);
    run(40);

    wait_phase(0);
    drive_load(16'h9876, 4'b0001);
    run(20);

    drive_load(16'hABCD, 4'b0000);
    run(40);

    lz_en = 1'b1;
    drive_load(16'h0004, 4'b0100);
    run(36);
    lz_en = 1'b0;
    drive_load(16'h1234, 4'b0100);
    run(36);

    blank_in = 1'b1;
    run(20);
    blank_in = 1'b0;
    run(10);

    wait_phase(5);
    drive_load(16'h7777, 4'b1111);
    run(1);
    async_reset_check();
    run(48);

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < ND; i++)
          v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        value_in = v;
        dp_in    = 4'($urandom_range(0, 15));
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 39) == 0) blank_in = ~blank_in;
      if (c == 1000) begin
        load = 1'b0;
        async_reset_check();
      end
      @(negedge clk);
    end
    load = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
